// File: rtl/avmm_pio_debounce.sv
// Purpose : Avalon-MM PIO with atomic set/clear outputs and synchronised, debounced, edge-captured inputs.
// Latency : read data 1 cycle after avs_read; input to DATA_IN 2+DEB_CYCLES cycles, EDGE_CAP/irq one cycle later.
// Backpr. : none; no waitrequest, every read/write strobe completes in the cycle it is sampled.
//
// Ports: clk/reset (sync, active-high); avs_address/read/write/writedata/readdata slave port;
//        irq level interrupt = |(EDGE_CAP & IRQ_MASK); pio_in async inputs; pio_out = DATA_OUT.
// Build option: define PIO_DEBOUNCE_EN to include the per-bit debouncer; otherwise the
//        synchroniser output feeds edge detection directly and DEB_CYCLES is unused.
module avmm_pio_debounce #(
    parameter int              IN_W       = 4,
    parameter int              OUT_W      = 8,
    parameter int              DEB_CYCLES = 50000,
    parameter logic [OUT_W-1:0] OUT_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    input  logic [IN_W-1:0]   pio_in,
    output logic [OUT_W-1:0]  pio_out
);

    logic [IN_W-1:0]  sync1_q, sync2_q;
    logic [IN_W-1:0]  deb;
    logic [IN_W-1:0]  deb_prev_q;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic [IN_W-1:0]  mask_q, mask_d;
    logic [IN_W-1:0]  cap_q, cap_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [IN_W-1:0]  edges;
    logic [IN_W-1:0]  w1c;

    // Only the low OUT_W / IN_W / 2 bits of write data are meaningful.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic [CNT_W-1:0] cnt_q [IN_W];
    logic [CNT_W-1:0] cnt_d [IN_W];
    logic [IN_W-1:0]  deb_q, deb_d;

    // Counter measures how long sync has disagreed with deb; any agreement restarts it,
    // so only an input held for DEB_CYCLES consecutive cycles is accepted.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < IN_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= '0;
            for (int i = 0; i < IN_W; i++) cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < IN_W; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign deb = deb_q;
`else
    logic unused_deb_cycles;
    assign unused_deb_cycles = (DEB_CYCLES != 0);
    assign deb = sync2_q;
`endif

    // Edge qualification: 0 rising, 1 falling, 2 both, 3 none.
    always_comb begin
        edges = '0;
        case (mode_q)
            2'd0:    edges = deb & ~deb_prev_q;
            2'd1:    edges = ~deb & deb_prev_q;
            2'd2:    edges = deb ^ deb_prev_q;
            default: edges = '0;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        mask_d = mask_q;
        mode_d = mode_q;
        w1c    = '0;
        if (avs_write) begin
            case (avs_address)
                3'd1:    dout_d = avs_writedata[OUT_W-1:0];
                3'd2:    dout_d = dout_q | avs_writedata[OUT_W-1:0];
                3'd3:    dout_d = dout_q & ~avs_writedata[OUT_W-1:0];
                3'd4:    mask_d = avs_writedata[IN_W-1:0];
                3'd5:    w1c    = avs_writedata[IN_W-1:0];
                3'd6:    mode_d = avs_writedata[1:0];
                default: ;
            endcase
        end
        // A new edge overrides a simultaneous clear of the same bit.
        cap_d = (cap_q & ~w1c) | edges;
    end

    // Read mux samples pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                3'd0:    rdata_d[IN_W-1:0]  = deb;
                3'd1:    rdata_d[OUT_W-1:0] = dout_q;
                3'd4:    rdata_d[IN_W-1:0]  = mask_q;
                3'd5:    rdata_d[IN_W-1:0]  = cap_q;
                3'd6:    rdata_d[1:0]       = mode_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_prev_q <= '0;
            dout_q     <= OUT_RESET;
            mask_q     <= '0;
            cap_q      <= '0;
            mode_q     <= '0;
            rdata_q    <= '0;
        end else begin
            sync1_q    <= pio_in;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb;
            dout_q     <= dout_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            mode_q     <= mode_d;
            rdata_q    <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign pio_out      = dout_q;
    assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_avmm_pio_debounce.sv
module tb_avmm_pio_debounce;

    localparam int IN_W  = 4;
    localparam int OUT_W = 8;
    localparam int DEB   = 4;
`ifdef PIO_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              irq;
    logic [IN_W-1:0]   pio_in;
    logic [OUT_W-1:0]  pio_out;

    avmm_pio_debounce #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEB_CYCLES(DEB), .OUT_RESET(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .pio_in(pio_in), .pio_out(pio_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: input history per clock edge plus architectural register values.
    logic [IN_W-1:0]  hist [0:8191];
    int               n = 32;
    logic [OUT_W-1:0] m_dout = 8'hA5;
    logic [IN_W-1:0]  m_mask = '0, m_cap = '0, m_deb = '0, m_deb_last = '0;
    logic [1:0]       m_mode = '0;
    logic [31:0]      m_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Debounced value of one bit: it flips only after the synchronised input has shown the
    // opposite value for DEB consecutive edges; without the debouncer it is just the
    // input delayed through two flops.
    function automatic logic [IN_W-1:0] next_deb();
        logic [IN_W-1:0] r;
        r = m_deb;
        for (int b = 0; b < IN_W; b++) begin
            if (DEB_ON) begin
                bit all_opp = 1'b1;
                for (int k = n - 1 - DEB; k <= n - 2; k++)
                    if (hist[k][b] == m_deb[b]) all_opp = 1'b0;
                if (all_opp) r[b] = ~m_deb[b];
            end else begin
                r[b] = hist[n-1][b];
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic rd, input logic wr,
                              input logic [2:0] a, input logic [31:0] wd, input logic [IN_W-1:0] pin);
        logic [IN_W-1:0] ev, clr, nd;
        if (rst) begin
            for (int k = n - 16; k <= n; k++) hist[k] = '0;
            m_dout = 8'hA5; m_mask = '0; m_cap = '0; m_mode = '0;
            m_rd = '0; m_deb = '0; m_deb_last = '0;
        end else begin
            hist[n] = pin;
            case (m_mode)
                2'd0: ev = m_deb & ~m_deb_last;
                2'd1: ev = ~m_deb & m_deb_last;
                2'd2: ev = m_deb ^ m_deb_last;
                default: ev = '0;
            endcase
            if (rd) begin
                case (a)
                    3'd0: m_rd = 32'(m_deb);
                    3'd1: m_rd = 32'(m_dout);
                    3'd4: m_rd = 32'(m_mask);
                    3'd5: m_rd = 32'(m_cap);
                    3'd6: m_rd = 32'(m_mode);
                    default: m_rd = 32'd0;
                endcase
            end
            clr = (wr && a == 3'd5) ? wd[IN_W-1:0] : '0;
            m_cap = (m_cap & ~clr) | ev;
            if (wr) begin
                case (a)
                    3'd1: m_dout = wd[OUT_W-1:0];
                    3'd2: m_dout = m_dout | wd[OUT_W-1:0];
                    3'd3: m_dout = m_dout & ~wd[OUT_W-1:0];
                    3'd4: m_mask = wd[IN_W-1:0];
                    3'd6: m_mode = wd[1:0];
                    default: ;
                endcase
            end
            nd = next_deb();
            m_deb_last = m_deb;
            m_deb = nd;
        end
        n++;
    endtask

    task automatic cyc(input logic rst, input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd, input logic [IN_W-1:0] pin);
        reset = rst; avs_read = rd; avs_write = wr; avs_address = a;
        avs_writedata = wd; pio_in = pin;
        @(posedge clk);
        model_step(rst, rd, wr, a, wd, pin);
        #1;
        check("pio_out", 32'(pio_out), 32'(m_dout));
        check("irq", 32'(irq), 32'(m_mask & m_cap) != 0 ? 32'd1 : 32'd0);
        check("readdata", avs_readdata, m_rd);
    endtask

    initial begin
        logic [IN_W-1:0] pin;
        pin = '0;
        for (int k = 0; k < 8192; k++) hist[k] = '0;

        // Reset state
        cyc(1, 0, 0, 0, 0, pin);
        cyc(1, 0, 0, 0, 0, pin);
        check("reset_pio_out", 32'(pio_out), 32'h0000_00A5);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_readdata", avs_readdata, 32'd0);

        // Output register: write, set, clear, read back
        cyc(0, 0, 1, 3'd1, 32'h1F0, pin);
        check("dout_write", 32'(pio_out), 32'h0000_00F0);
        cyc(0, 0, 1, 3'd2, 32'h0F, pin);
        check("dout_set", 32'(pio_out), 32'h0000_00FF);
        cyc(0, 0, 1, 3'd3, 32'h81, pin);
        check("dout_clr", 32'(pio_out), 32'h0000_007E);
        cyc(0, 1, 0, 3'd1, 0, pin);
        check("dout_read", avs_readdata, 32'h0000_007E);

        // Write-only and reserved addresses read zero
        cyc(0, 1, 0, 3'd2, 0, pin);
        check("read_set_zero", avs_readdata, 32'd0);
        cyc(0, 1, 0, 3'd1, 0, pin);
        cyc(0, 1, 0, 3'd3, 0, pin);
        check("read_clr_zero", avs_readdata, 32'd0);
        cyc(0, 1, 0, 3'd1, 0, pin);
        cyc(0, 1, 0, 3'd7, 0, pin);
        check("read_rsvd_zero", avs_readdata, 32'd0);

        // Held rising input on bit 0, polling DATA_IN
        pin = 4'b0001;
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 3'd0, 0, pin);
        check("data_in_bit0", avs_readdata, 32'd1);
        cyc(0, 1, 0, 3'd5, 0, pin);
        check("edge_cap_bit0", avs_readdata, 32'd1);

        // Short pulse on bit 1 (filtered only with the debouncer)
        pin = 4'b0011;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'd0, 0, pin);
        pin = 4'b0001;
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 3'd5, 0, pin);

        // Edge modes on bit 2: falling only, both, none
        for (int m = 1; m <= 3; m++) begin
            cyc(0, 0, 1, 3'd5, 32'hF, pin);
            cyc(0, 0, 1, 3'd6, 32'(m), pin);
            pin[2] = 1'b1;
            for (int i = 0; i < 10; i++) cyc(0, 1, 0, 3'd5, 0, pin);
            pin[2] = 1'b0;
            for (int i = 0; i < 10; i++) cyc(0, 1, 0, 3'd5, 0, pin);
        end

        // Interrupt masking with EDGE_CAP = 0x6
        cyc(0, 0, 1, 3'd5, 32'hF, pin);
        cyc(0, 0, 1, 3'd6, 32'd2, pin);
        pin = 4'b0111;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, pin);
        cyc(0, 0, 1, 3'd4, 32'h1, pin);
        check("irq_masked", 32'(irq), 32'd0);
        cyc(0, 0, 1, 3'd4, 32'h4, pin);
        check("irq_unmasked", 32'(irq), 32'd1);
        cyc(0, 0, 1, 3'd5, 32'h4, pin);
        check("irq_w1c", 32'(irq), 32'd0);

        // W1C of bit 0 in the very cycle its edge is detected
        pin[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_deb[0] != m_deb_last[0]) cyc(0, 0, 1, 3'd5, 32'h1, pin);
            else                           cyc(0, 0, 0, 0, 0, pin);
        end
        cyc(0, 1, 0, 3'd5, 0, pin);
        check("w1c_edge_wins", 32'(avs_readdata[0]), 32'd1);

        // Bit 3 rising with mask 0x8; then reset mid-sequence
        cyc(0, 0, 1, 3'd4, 32'h8, pin);
        cyc(0, 0, 1, 3'd6, 32'd0, pin);
        pin[3] = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'd0, 0, pin);
        cyc(1, 0, 0, 0, 0, pin);
        check("mid_reset_pio_out", 32'(pio_out), 32'h0000_00A5);
        check("mid_reset_irq", 32'(irq), 32'd0);
        check("mid_reset_readdata", avs_readdata, 32'd0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 3'd0, 0, pin);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] a;
            if ($urandom_range(0, 4) == 0) pin = pin ^ IN_W'($urandom);
            a = 3'($urandom);
            cyc(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                a, $urandom, pin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
